// File: rtl/call_push_unit.sv
// CALL engine: allocates a stack frame, pushes the return address through a req/ack
// write port, then commits PC/SP/RA. Optional macro STACK_LIMIT_EN adds a stack-limit fault.
module call_push_unit #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] pcIn,
  input  logic [DATA_W-1:0] spIn,
  input  logic [DATA_W-1:0] raIn,
  input  logic [DATA_W-1:0] stack_limit,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pcOut,
  output logic [DATA_W-1:0] spOut,
  output logic [DATA_W-1:0] raOut,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fsm_state
);

  // Handshake: mem_we/mem_addr/mem_wdata are held stable from the cycle after
  // the accepted start until the clock edge at which mem_ack is sampled high.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] off;
  logic [DATA_W-1:0] nsp;
  logic              start_fault;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] target_q;

  // Same encoding as the return ALU, so RETURN with this immediate undoes the CALL.
  always_comb begin
    imm_ext = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
    off     = imm_ext << 1;
    nsp     = spIn - off;
  end

`ifdef STACK_LIMIT_EN
  logic borrow;
  always_comb begin
    borrow      = !immediate[IMM_W-1] && (off > spIn);
    start_fault = (nsp < stack_limit) || borrow;
  end
`else
  logic unused_limit;
  assign unused_limit = ^stack_limit;
  assign start_fault  = 1'b0;
`endif

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = start_fault ? DONE : WRITE;
      WRITE:   if (mem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      pcOut     <= '0;
      spOut     <= '0;
      raOut     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      pc_q      <= '0;
      target_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (start_fault) begin
              // Rejected frame: report and leave architectural state untouched.
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= nsp;
              mem_wdata <= raIn;
              pc_q      <= pcIn;
              target_q  <= target;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            spOut  <= mem_addr;
            raOut  <= pc_q + DATA_W'(2);
            pcOut  <= target_q;
            done   <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          mem_we <= 1'b0;
          done   <= 1'b0;
          fault  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_push_unit.sv
// Bench for call_push_unit: scoreboard of expected writes and commits, scenario tasks.
module tb_call_push_unit;

  logic        clk = 1'b0;
  logic        reset, start, mem_ack;
  logic [9:0]  immediate;
  logic [15:0] target, pcIn, spIn, raIn, stack_limit;
  logic [15:0] mem_addr, mem_wdata, pcOut, spOut, raOut;
  logic        mem_we, busy, done, fault;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [48:0] exp_done_q[$];
  logic [31:0] e_wr;
  logic [48:0] e_dn;
  logic [15:0] cur_pc = '0, cur_sp = '0, cur_ra = '0;

  call_push_unit dut (
    .clk(clk), .reset(reset), .start(start), .immediate(immediate),
    .target(target), .pcIn(pcIn), .spIn(spIn), .raIn(raIn),
    .stack_limit(stack_limit), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ack(mem_ack), .pcOut(pcOut), .spOut(spOut),
    .raOut(raOut), .busy(busy), .done(done), .fault(fault), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: writes are popped when acknowledged, commits when done pulses.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mem_we === 1'b1 && mem_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected addr=%h data=%h", mem_addr, mem_wdata);
        end else begin
          e_wr = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== e_wr) begin
            errors++;
            $display("FAIL write_data got=%h exp=%h", {mem_addr, mem_wdata}, e_wr);
          end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected pc=%h sp=%h ra=%h fault=%b", pcOut, spOut, raOut, fault);
        end else begin
          e_dn = exp_done_q.pop_front();
          if ({pcOut, spOut, raOut, fault} !== e_dn) begin
            errors++;
            $display("FAIL commit got=%h exp=%h", {pcOut, spOut, raOut, fault}, e_dn);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Drives one call; wcycles = number of WRITE cycles before (and including) the ack cycle.
  task automatic run_call(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] ra,
                          input logic [15:0] tgt, input logic [9:0] imm, input int wcycles,
                          input bit poke);
    logic [15:0] off, nsp;
    logic exp_fault;
    off = {{6{imm[9]}}, imm};
    off = off << 1;
    nsp = sp - off;
`ifdef STACK_LIMIT_EN
    exp_fault = (nsp < stack_limit) || (!imm[9] && (off > sp));
`else
    exp_fault = 1'b0;
`endif
    if (exp_fault) begin
      exp_done_q.push_back({cur_pc, cur_sp, cur_ra, 1'b1});
    end else begin
      exp_q.push_back({nsp, ra});
      exp_done_q.push_back({tgt, nsp, pc + 16'd2, 1'b0});
      cur_pc = tgt;
      cur_sp = nsp;
      cur_ra = pc + 16'd2;
    end
    pcIn = pc; spIn = sp; raIn = ra; target = tgt; immediate = imm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!exp_fault) begin
      for (int c = 1; c <= wcycles; c++) begin
        if (c == wcycles) mem_ack = 1'b1;
        if (poke) begin
          start = 1'b1; spIn = ~sp; raIn = ~ra; pcIn = ~pc;
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== nsp || mem_wdata !== ra || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL write_hold cyc=%0d we=%b addr=%h data=%h busy=%b done=%b exp_addr=%h exp_data=%h",
                   c, mem_we, mem_addr, mem_wdata, busy, done, nsp, ra);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b0; spIn = sp; raIn = ra; pcIn = pc;
      end
    end
    if (poke) start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || fault !== exp_fault) begin
      errors++;
      $display("FAIL done_cycle done=%b busy=%b we=%b fault=%b exp_fault=%b", done, busy, mem_we, fault, exp_fault);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL back_to_idle done=%b busy=%b we=%b state=%0d exp=0,0,0,0", done, busy, mem_we, fsm_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; immediate = '0; target = '0;
    pcIn = '0; spIn = '0; raIn = '0; stack_limit = 16'h0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pcOut, spOut, raOut, mem_addr, mem_wdata} !== 80'd0 ||
        {mem_we, busy, done, fault} !== 4'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values pc=%h sp=%h ra=%h addr=%h data=%h we=%b busy=%b done=%b fault=%b",
               pcOut, spOut, raOut, mem_addr, mem_wdata, mem_we, busy, done, fault);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_call();
    run_call(16'h0100, 16'h8000, 16'h1234, 16'h0400, 10'd4, 1, 1'b0);
    checks++;
    if (spOut !== 16'h7FF8 || raOut !== 16'h0102 || pcOut !== 16'h0400) begin
      errors++;
      $display("FAIL basic_commit sp=%h ra=%h pc=%h exp=7ff8 0102 0400", spOut, raOut, pcOut);
    end
  endtask

  task automatic test_ack_delay();
    run_call(16'h0200, 16'h6000, 16'hBEEF, 16'h0A00, 10'd8, 3, 1'b1);
    checks++;
    if (spOut !== 16'h5FF0 || pcOut !== 16'h0A00 || raOut !== 16'h0202) begin
      errors++;
      $display("FAIL delay_commit sp=%h pc=%h ra=%h exp=5ff0 0a00 0202", spOut, pcOut, raOut);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] pc0;
    pc0 = cur_pc;
    run_call(16'h0300, 16'h0004, 16'h5555, 16'h0600, 10'd4, 1, 1'b0);
    checks++;
`ifdef STACK_LIMIT_EN
    if (pcOut !== pc0) begin
      errors++;
      $display("FAIL wrap_fault_unchanged pc=%h exp=%h", pcOut, pc0);
    end
`else
    if (spOut !== 16'hFFFC || pcOut === pc0) begin
      errors++;
      $display("FAIL wrap_sp sp=%h exp=fffc pc=%h", spOut, pcOut);
    end
`endif
  endtask

  task automatic test_negative_imm();
    run_call(16'h0110, 16'h8000, 16'h2222, 16'h0800, 10'h3FE, 2, 1'b0);
    checks++;
    if (spOut !== 16'h8004 || raOut !== 16'h0112) begin
      errors++;
      $display("FAIL neg_imm sp=%h ra=%h exp=8004 0112", spOut, raOut);
    end
  endtask

  task automatic test_reset_mid_write();
    pcIn = 16'h0100; spIn = 16'h8000; raIn = 16'h1234; target = 16'h0400; immediate = 10'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pcOut, spOut, raOut} !== 48'd0 || {mem_we, busy, done, fault} !== 4'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_write pc=%h sp=%h ra=%h we=%b busy=%b done=%b", pcOut, spOut, raOut, mem_we, busy, done);
    end
    reset = 1'b0;
    cur_pc = '0; cur_sp = '0; cur_ra = '0;
    @(posedge clk); #1;
    test_basic_call();
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || fsm_state !== 2'd0 ||
          pcOut !== cur_pc || spOut !== cur_sp || raOut !== cur_ra) begin
        errors++;
        $display("FAIL spurious_ack we=%b done=%b busy=%b pc=%h sp=%h ra=%h exp pc=%h sp=%h ra=%h",
                 mem_we, done, busy, pcOut, spOut, raOut, cur_pc, cur_sp, cur_ra);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_call(16'($urandom_range(0, 16'hFFFE)), 16'($urandom_range(16'h2000, 16'hFFF0)),
               16'($urandom), 16'($urandom), 10'($urandom_range(0, 10'h3FF)),
               int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic_call();
    test_ack_delay();
    test_spurious_ack();
    test_wrap();
    test_negative_imm();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain writes_left=%0d commits_left=%0d exp=0", exp_q.size(), exp_done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_push_unit.md
# call_push_unit

Sequential CALL engine: the push-side counterpart of the RETURN datapath. On a call request it allocates a stack frame, writes the current return address to stack memory through a req/ack write port, then commits the new PC, SP and RA. Sits beside the return ALU in the control-flow unit, and shares the frame-size immediate encoding with it so that a RETURN with the same immediate exactly undoes a CALL.

## Interface
- DATA_W, 16, datapath and address width
- IMM_W, 10, frame-size immediate width in words; sign-extended, then shifted left by 1

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  call request, sampled in IDLE only
- immediate  in  IMM_W  frame size in words (signed)
- target  in  DATA_W  call destination address
- pcIn / spIn / raIn  in  DATA_W  current PC, SP, RA; captured on accepted start
- stack_limit  in  DATA_W  lowest legal SP (used only with STACK_LIMIT_EN)
- mem_addr  out  DATA_W  stack write address
- mem_wdata  out  DATA_W  stack write data
- mem_we  out  1  write request, held until acknowledged
- mem_ack  in  1  write accepted
- pcOut / spOut / raOut  out  DATA_W  committed PC, SP, RA
- busy  out  1  high in WRITE and DONE
- done  out  1  one-cycle completion pulse
- fault  out  1  stack-limit violation flag, valid while done=1

## Operation
- Clocking is decided: one clock; reset is synchronous and active-high.
- Frame offset: off = sign_extend(immediate) << 1, mod 2^DATA_W.
- New SP: nsp = spIn − off, mod 2^DATA_W. Wrap-around is silent unless STACK_LIMIT_EN is defined.
- States: IDLE, WRITE, DONE.
- IDLE: when start=1, capture pcIn, spIn, raIn, target and nsp; go to WRITE. start in any other state is ignored.
- WRITE: mem_we=1, mem_addr=nsp, mem_wdata=captured raIn, all held stable. On the edge where mem_ack=1:
  - spOut ← nsp
  - raOut ← captured pcIn + 2
  - pcOut ← captured target
  - next state DONE
- DONE: done=1 for one cycle; fault=0; then IDLE.
- mem_ack outside WRITE is ignored.
- All outputs are registered.
- Reset values: pcOut=0, spOut=0, raOut=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, fault=0; state IDLE.
- Reset mid-operation: any state goes to IDLE at the reset edge. mem_we is low the cycle after. pcOut, spOut and raOut return to 0. No partial commit.

## Timing
- Accepted start at edge N: mem_we high from cycle N+1.
- mem_ack first sampled high at edge N+k (k≥1): outputs update at that edge; done high during cycle N+k+1; IDLE after edge N+k+1.
- Minimum start-to-done: 2 cycles. Next start is accepted at the edge that ends DONE+1, i.e. while in IDLE.
- mem_ack high in the first WRITE cycle is legal and is honoured.

## Configuration
- STACK_LIMIT_EN defined: in IDLE, fault is computed at start.
  - Fault condition: nsp < stack_limit (unsigned), or spIn − off borrowed (off > spIn when off is non-negative).
  - On fault: go directly to DONE without asserting mem_we. pcOut, spOut and raOut are unchanged. done=1 and fault=1 for one cycle.
- STACK_LIMIT_EN undefined: stack_limit is ignored, fault is constant 0, and wrap-around proceeds normally.

## Test plan
- Basic call: spIn=0x8000, raIn=0x1234, pcIn=0x0100, target=0x0400, immediate=4, ack after 1 cycle.
  - Required: mem_addr=0x7FF8, mem_wdata=0x1234, mem_we for 1 cycle.
  - Then spOut=0x7FF8, raOut=0x0102, pcOut=0x0400, single done pulse.
- Ack delay of 3 cycles: mem_we and address/data held stable for 3 cycles; done exactly once, one cycle after ack; start pulses during busy are ignored with no second write.
- Wrap: spIn=0x0004, immediate=4.
  - Macro off: mem_addr=spOut=0xFFFC.
  - Macro on with stack_limit=0x0100: fault=1 with done, no mem_we, outputs unchanged.
- Negative immediate: immediate=10'h3FE (−2), spIn=0x8000 → nsp=0x8004 (off=0xFFFC); commit as normal.
- Reset asserted during WRITE with ack never given: mem_we=0 and all outputs 0 one cycle after the reset edge; a following call (basic values) completes correctly.
- Spurious mem_ack in IDLE: no state change, no output change.
